// File: rtl/conway_pkg.sv
// Shared types for the serial Game of Life slice.
//   mode_t      : external 2-bit mode encoding (load/run/output/hold)
//   run_state_t : run controller FSM states
//   data_size() : number of cells on a GRID_WIDTH x GRID_HEIGHT board
package conway_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD   = 2'b00,
    MODE_RUN    = 2'b01,
    MODE_OUTPUT = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  typedef enum logic {
    RUN_IDLE   = 1'b0,
    RUN_ACTIVE = 1'b1
  } run_state_t;

  function automatic int data_size(input int width, input int height);
    return width * height;
  endfunction

endpackage

// File: rtl/cell_grid.sv
// Combinational Game of Life step for a GRID_WIDTH x GRID_HEIGHT board.
// Cells outside the board are treated as dead.
//   board      : current board, bit index = row*GRID_WIDTH + col
//   next_state : board after one generation
module cell_grid #(
  parameter int GRID_WIDTH  = 8,
  parameter int GRID_HEIGHT = 8
) (
  input  logic [GRID_WIDTH*GRID_HEIGHT-1:0] board,
  output logic [GRID_WIDTH*GRID_HEIGHT-1:0] next_state
);

  // Board surrounded by a ring of dead cells so every neighbour lookup
  // is in range without edge special cases.
  logic [GRID_HEIGHT+1:0][GRID_WIDTH+1:0] pad;

  always_comb begin
    pad = '0;
    for (int unsigned r = 0; r < GRID_HEIGHT; r++) begin
      for (int unsigned c = 0; c < GRID_WIDTH; c++) begin
        pad[r+1][c+1] = board[r*GRID_WIDTH + c];
      end
    end
  end

  always_comb begin
    logic [3:0] n;
    next_state = '0;
    for (int unsigned r = 0; r < GRID_HEIGHT; r++) begin
      for (int unsigned c = 0; c < GRID_WIDTH; c++) begin
        n = '0;
        for (int unsigned dr = 0; dr < 3; dr++) begin
          for (int unsigned dc = 0; dc < 3; dc++) begin
            if (!(dr == 1 && dc == 1)) begin
              n = n + 4'(pad[r+dr][c+dc]);
            end
          end
        end
        next_state[r*GRID_WIDTH + c] = (n == 4'd3) || (pad[r+1][c+1] && n == 4'd2);
      end
    end
  end

endmodule

// File: rtl/conway_run_ctrl.sv
// Run controller: start/busy/done handshake, generation counter and
// termination detection (request reached, still-life, extinction).
//   run_mode   : top is in run mode; leaving it while busy aborts silently
//   start      : run request, honoured only when idle and in run mode
//   gen_req    : generations to run, 0 = until stable or extinct
//   next_equal : next board equals current board
//   next_zero  : next board is empty
//   advance    : load next board this cycle
//   busy/done/stable/generation : status outputs
module conway_run_ctrl
  import conway_pkg::*;
#(
  parameter int GEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run_mode,
  input  logic                 start,
  input  logic [GEN_WIDTH-1:0] gen_req,
  input  logic                 next_equal,
  input  logic                 next_zero,
  output logic                 advance,
  output logic                 busy,
  output logic                 done,
  output logic                 stable,
  output logic [GEN_WIDTH-1:0] generation
);

  run_state_t           state, state_n;
  logic [GEN_WIDTH-1:0] req_q, req_n;
  logic [GEN_WIDTH-1:0] gen_q, gen_n;
  logic                 stable_q, stable_n;
  logic                 done_q, done_n;
  logic [GEN_WIDTH:0]   gen_inc;
  logic                 count_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN_IDLE;
      req_q    <= '0;
      gen_q    <= '0;
      stable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      req_q    <= req_n;
      gen_q    <= gen_n;
      stable_q <= stable_n;
      done_q   <= done_n;
    end
  end

  // Compare against the request one bit wider so a saturated counter
  // can never wrap into a false match.
  assign gen_inc   = {1'b0, gen_q} + (GEN_WIDTH+1)'(1);
  assign count_hit = (req_q != '0) && (gen_inc == {1'b0, req_q});

  always_comb begin
    state_n  = state;
    req_n    = req_q;
    gen_n    = gen_q;
    stable_n = stable_q;
    done_n   = 1'b0;
    advance  = 1'b0;
    unique case (state)
      RUN_IDLE: begin
        if (run_mode && start) begin
          req_n    = gen_req;
          gen_n    = '0;
          stable_n = 1'b0;
          state_n  = RUN_ACTIVE;
        end
      end
      RUN_ACTIVE: begin
        if (!run_mode) begin
          state_n = RUN_IDLE;
        end else begin
          advance = 1'b1;
          if (gen_q != '1) begin
            gen_n = gen_q + GEN_WIDTH'(1);
          end
          if (count_hit || next_equal || next_zero) begin
            state_n  = RUN_IDLE;
            done_n   = 1'b1;
            stable_n = next_equal;
          end
        end
      end
      default: state_n = RUN_IDLE;
    endcase
  end

  assign busy       = (state == RUN_ACTIVE);
  assign done       = done_q;
  assign stable     = stable_q;
  assign generation = gen_q;

endmodule

// File: rtl/conway_serial_v4.sv
// Serial Game of Life top level with bounded multi-generation runs.
//   clk, reset      : clock, asynchronous active-low reset
//   mode            : 00 load, 01 run, 10 output, 11 hold
//   data_in         : serial board bit (load mode, MSB first)
//   start, gen_req  : run request and generation count (0 = free run)
//   data_out        : serial board bit, qualified by out_valid
//   load_full       : a full board has been shifted in this load session
//   busy, done      : run in progress / one-cycle completion pulse
//   stable, extinct : still-life detected / board empty
//   generation      : generations completed in current run
//   din_led, clk_led, dout_led, mode_leds : mirrors for board LEDs
module conway_serial_v4
  import conway_pkg::*;
#(
  parameter int GRID_WIDTH  = 8,
  parameter int GRID_HEIGHT = 8,
  parameter int GEN_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 data_in,
  input  logic                 start,
  input  logic [GEN_WIDTH-1:0] gen_req,
  output logic                 data_out,
  output logic                 out_valid,
  output logic                 load_full,
  output logic                 busy,
  output logic                 done,
  output logic                 stable,
  output logic                 extinct,
  output logic [GEN_WIDTH-1:0] generation,
  output logic                 din_led,
  output logic                 clk_led,
  output logic                 dout_led,
  output logic [1:0]           mode_leds
);

  localparam int DS = data_size(GRID_WIDTH, GRID_HEIGHT);
  localparam int CW = $clog2(DS + 1);
  localparam logic [CW-1:0] FULL = CW'(DS);

  mode_t          mode_e;
  logic [DS-1:0]  board;
  logic [DS-1:0]  next_state;
  logic [CW-1:0]  load_cnt;
  logic [CW-1:0]  out_cnt;
  logic           data_out_q;
  logic           out_valid_q;
  logic           advance;

  assign mode_e = mode_t'(mode);

  cell_grid #(
    .GRID_WIDTH (GRID_WIDTH),
    .GRID_HEIGHT(GRID_HEIGHT)
  ) u_grid (
    .board     (board),
    .next_state(next_state)
  );

  conway_run_ctrl #(
    .GEN_WIDTH(GEN_WIDTH)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (reset),
    .run_mode  (mode_e == MODE_RUN),
    .start     (start),
    .gen_req   (gen_req),
    .next_equal(next_state == board),
    .next_zero (next_state == '0),
    .advance   (advance),
    .busy      (busy),
    .done      (done),
    .stable    (stable),
    .generation(generation)
  );

  // Board register: serial in, generation step, destructive serial out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      board <= '0;
    end else begin
      unique case (mode_e)
        MODE_LOAD:   board <= {board[DS-2:0], data_in};
        MODE_RUN:    if (advance) board <= next_state;
        MODE_OUTPUT: board <= {board[DS-2:0], 1'b0};
        MODE_HOLD:   board <= board;
        default:     board <= board;
      endcase
    end
  end

  // Load counter saturates at a full board; any other mode clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_cnt <= '0;
    end else if (mode_e != MODE_LOAD) begin
      load_cnt <= '0;
    end else if (load_cnt != FULL) begin
      load_cnt <= load_cnt + CW'(1);
    end
  end

  // Output window: exactly DS qualified bits per entry into output mode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_cnt     <= '0;
      data_out_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (mode_e == MODE_OUTPUT && out_cnt != FULL) begin
      data_out_q  <= board[DS-1];
      out_valid_q <= 1'b1;
      out_cnt     <= out_cnt + CW'(1);
    end else begin
      data_out_q  <= 1'b0;
      out_valid_q <= 1'b0;
      if (mode_e != MODE_OUTPUT) begin
        out_cnt <= '0;
      end
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign load_full = (load_cnt == FULL);
  assign extinct   = (board == '0);

  assign din_led   = data_in;
  assign clk_led   = clk;
  assign dout_led  = data_out_q;
  assign mode_leds = mode;

endmodule

// File: tb/tb_conway_serial_v4.sv
module tb_conway_serial_v4;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_in;
  logic        start;
  logic [15:0] gen_req;
  logic [1:0]  mode8, mode5;

  logic        d8_dout, d8_valid, d8_full, d8_busy, d8_done, d8_stable, d8_ext;
  logic [15:0] d8_gen;
  logic        d8_dinl, d8_clkl, d8_doutl;
  logic [1:0]  d8_model;

  logic        d5_dout, d5_valid, d5_full, d5_busy, d5_done, d5_stable, d5_ext;
  logic [2:0]  d5_gen;
  logic        d5_dinl, d5_clkl, d5_doutl;
  logic [1:0]  d5_model;

  always #5 clk = ~clk;

  conway_serial_v4 #(.GRID_WIDTH(8), .GRID_HEIGHT(8), .GEN_WIDTH(16)) dut8 (
    .clk(clk), .reset(reset), .mode(mode8), .data_in(data_in), .start(start),
    .gen_req(gen_req), .data_out(d8_dout), .out_valid(d8_valid), .load_full(d8_full),
    .busy(d8_busy), .done(d8_done), .stable(d8_stable), .extinct(d8_ext),
    .generation(d8_gen), .din_led(d8_dinl), .clk_led(d8_clkl), .dout_led(d8_doutl),
    .mode_leds(d8_model)
  );

  conway_serial_v4 #(.GRID_WIDTH(5), .GRID_HEIGHT(4), .GEN_WIDTH(3)) dut5 (
    .clk(clk), .reset(reset), .mode(mode5), .data_in(data_in), .start(start),
    .gen_req(gen_req[2:0]), .data_out(d5_dout), .out_valid(d5_valid), .load_full(d5_full),
    .busy(d5_busy), .done(d5_done), .stable(d5_stable), .extinct(d5_ext),
    .generation(d5_gen), .din_led(d5_dinl), .clk_led(d5_clkl), .dout_led(d5_doutl),
    .mode_leds(d5_model)
  );

  // Selected DUT view (0 = 8x8, 1 = 5x4).
  logic        sel;
  logic        o_dout, o_valid, o_full, o_busy, o_done, o_stable, o_ext;
  logic [15:0] o_gen;

  always_comb begin
    if (sel) begin
      o_dout = d5_dout; o_valid = d5_valid; o_full = d5_full; o_busy = d5_busy;
      o_done = d5_done; o_stable = d5_stable; o_ext = d5_ext; o_gen = {13'b0, d5_gen};
    end else begin
      o_dout = d8_dout; o_valid = d8_valid; o_full = d8_full; o_busy = d8_busy;
      o_done = d8_done; o_stable = d8_stable; o_ext = d8_ext; o_gen = d8_gen;
    end
  end

  int ntests = 0;
  int nfail  = 0;

  function automatic int w_of(); return sel ? 5 : 8; endfunction
  function automatic int h_of(); return sel ? 4 : 8; endfunction
  function automatic int ds_of(); return w_of() * h_of(); endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    if (sel) mode5 = m; else mode8 = m;
  endtask

  // Reference model: one Life generation on a w x h board with dead
  // surroundings, computed cell by cell from the neighbour count.
  function automatic logic [63:0] life(input logic [63:0] b, input int w, input int h);
    logic [63:0] r;
    r = '0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if ((dy != 0 || dx != 0) && y + dy >= 0 && y + dy < h && x + dx >= 0 && x + dx < w)
              n += int'(b[(y+dy)*w + (x+dx)]);
          end
        end
        if (n == 3 || (n == 2 && b[y*w + x])) r[y*w + x] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_run(input logic [63:0] b0, input int req, output int g,
                           output bit st, output logic [63:0] fin);
    logic [63:0] b, nx;
    bit stop;
    b = b0; g = 0; st = 1'b0; stop = 1'b0;
    while (!stop) begin
      nx = life(b, w_of(), h_of());
      g++;
      st = (nx == b);
      stop = st || (nx == '0) || (g == req);
      b = nx;
    end
    fin = b;
  endtask

  task automatic load_board(input logic [63:0] b);
    set_mode(2'b00);
    for (int i = ds_of() - 1; i >= 0; i--) begin
      if (i == 0) chk("load_full_early", 64'(o_full), 64'd0);
      data_in = b[i];
      step();
    end
    chk("load_full", 64'(o_full), 64'd1);
  endtask

  task automatic unload(input string nm, input logic [63:0] exp);
    logic [63:0] cap;
    int nv;
    cap = '0; nv = 0;
    set_mode(2'b10);
    for (int k = 0; k < ds_of() + 3; k++) begin
      step();
      if (k == 0) chk({nm, "_first_valid"}, 64'(o_valid), 64'd1);
      if (o_valid) begin
        cap = {cap[62:0], o_dout};
        nv++;
      end
    end
    chk({nm, "_stream"}, cap, exp);
    chk({nm, "_valid_cycles"}, 64'(nv), 64'(ds_of()));
    chk({nm, "_destructive"}, 64'(o_ext), 64'd1);
    set_mode(2'b11);
    step();
  endtask

  // Start a bounded run and wait (bounded) for the done pulse.
  task automatic run_gens(input string nm, input logic [15:0] req, input int exp_gen);
    int cyc;
    bit seen;
    set_mode(2'b01);
    gen_req = req;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({nm, "_busy_after_start"}, 64'(o_busy), 64'd1);
    cyc = 0; seen = 1'b0;
    while (cyc < 300 && !seen) begin
      step();
      cyc++;
      if (o_done) seen = 1'b1;
    end
    if (!seen) chk({nm, "_done_timeout"}, 64'd0, 64'd1);
    chk({nm, "_done_latency"}, 64'(cyc), 64'(exp_gen));
    chk({nm, "_busy_at_done"}, 64'(o_busy), 64'd0);
    chk({nm, "_generation"}, 64'(o_gen), 64'(exp_gen));
    step();
    chk({nm, "_done_single"}, 64'(o_done), 64'd0);
    set_mode(2'b11);
    step();
  endtask

  typedef struct {
    string       nm;
    logic [63:0] init;
    logic [15:0] req;
    int          gens;
    bit          stbl;
    logic [63:0] fin;
  } vec_t;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
  localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;

  initial begin
    vec_t tbl[6];
    logic [63:0] b, fin;
    int g, req;
    bit st, seen;

    tbl[0] = '{"blink3",  BLINK_H,            16'd3,  3, 1'b0, BLINK_V};
    tbl[1] = '{"blink1",  BLINK_H,            16'd1,  1, 1'b0, BLINK_V};
    tbl[2] = '{"blink2",  BLINK_H,            16'd2,  2, 1'b0, BLINK_H};
    tbl[3] = '{"block",   BLOCK,              16'd10, 1, 1'b1, BLOCK};
    tbl[4] = '{"single",  64'h0000_0000_0800_0000, 16'd0, 1, 1'b0, 64'd0};
    tbl[5] = '{"empty",   64'd0,              16'd5,  1, 1'b1, 64'd0};

    sel = 1'b0; reset = 1'b0; mode8 = 2'b11; mode5 = 2'b11;
    data_in = 1'b0; start = 1'b0; gen_req = '0;
    step(); step();
    chk("rst_data_out", 64'(d8_dout), 64'd0);
    chk("rst_out_valid", 64'(d8_valid), 64'd0);
    chk("rst_load_full", 64'(d8_full), 64'd0);
    chk("rst_busy", 64'(d8_busy), 64'd0);
    chk("rst_done", 64'(d8_done), 64'd0);
    chk("rst_stable", 64'(d8_stable), 64'd0);
    chk("rst_generation", 64'(d8_gen), 64'd0);
    chk("rst_extinct", 64'(d8_ext), 64'd1);
    reset = 1'b1;
    step();

    data_in = 1'b1; mode8 = 2'b11; #1;
    chk("din_led", 64'(d8_dinl), 64'd1);
    chk("mode_leds", 64'(d8_model), 64'd3);
    chk("clk_led", 64'(d8_clkl), 64'(clk));
    data_in = 1'b0;

    // start outside run mode is ignored
    start = 1'b1; step(); start = 1'b0;
    chk("start_in_hold_ignored", 64'(d8_busy), 64'd0);

    // Round trip of the blinker through load and output.
    load_board(BLINK_H);
    set_mode(2'b11); step();
    unload("roundtrip", BLINK_H);

    for (int i = 0; i < 6; i++) begin
      load_board(tbl[i].init);
      run_gens(tbl[i].nm, tbl[i].req, tbl[i].gens);
      chk({tbl[i].nm, "_stable"}, 64'(o_stable), 64'(tbl[i].stbl));
      chk({tbl[i].nm, "_extinct"}, 64'(o_ext), 64'(tbl[i].fin == 64'd0));
      unload(tbl[i].nm, tbl[i].fin);
    end

    // Random boards against the reference model.
    for (int i = 0; i < 8; i++) begin
      b = {$urandom, $urandom} & {$urandom, $urandom};
      req = int'($urandom_range(1, 12));
      model_run(b, req, g, st, fin);
      load_board(b);
      run_gens($sformatf("rnd%0d", i), 16'(req), g);
      chk($sformatf("rnd%0d_stable", i), 64'(o_stable), 64'(st));
      unload($sformatf("rnd%0d", i), fin);
    end

    // Glider aborted by hold at generation 5.
    load_board(GLIDER);
    set_mode(2'b01); gen_req = 16'd100; start = 1'b1;
    step(); start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin step(); if (o_done) seen = 1'b1; end
    chk("glider_gen5_busy", 64'(o_busy), 64'd1);
    chk("glider_gen5", 64'(o_gen), 64'd5);
    set_mode(2'b11);
    step(); if (o_done) seen = 1'b1;
    chk("glider_abort_busy", 64'(o_busy), 64'd0);
    for (int k = 0; k < 3; k++) begin step(); if (o_done) seen = 1'b1; end
    chk("glider_no_done", 64'(seen), 64'd0);
    chk("glider_gen_frozen", 64'(o_gen), 64'd5);
    b = GLIDER;
    for (int k = 0; k < 5; k++) b = life(b, 8, 8);
    unload("glider", b);

    // Asynchronous reset mid-run.
    load_board(BLINK_H);
    set_mode(2'b01); gen_req = 16'd0; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    reset = 1'b0; #1;
    chk("arst_busy", 64'(d8_busy), 64'd0);
    chk("arst_generation", 64'(d8_gen), 64'd0);
    chk("arst_extinct", 64'(d8_ext), 64'd1);
    set_mode(2'b11);
    step(); reset = 1'b1; step();
    chk("arst_no_done", 64'(d8_done), 64'd0);

    // 5x4 instance.
    sel = 1'b1;
    load_board(64'h1C0);
    run_gens("g5x4_blink1", 16'd1, 1);
    unload("g5x4_blink1", 64'h1084);
    load_board(64'h1C0);
    run_gens("g5x4_blink2", 16'd2, 2);
    unload("g5x4_blink2", 64'h1C0);

    // Free run past 3-bit generation saturation, then abort.
    load_board(64'h1C0);
    set_mode(2'b01); gen_req = 16'd0; start = 1'b1;
    step(); start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin step(); if (o_done) seen = 1'b1; end
    chk("sat_busy", 64'(o_busy), 64'd1);
    chk("sat_generation", 64'(o_gen), 64'd7);
    chk("sat_no_done", 64'(seen), 64'd0);
    set_mode(2'b11);
    step();
    chk("sat_abort_busy", 64'(o_busy), 64'd0);
    unload("sat", 64'h1C0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/conway_serial_v4.md
# conway_serial_v4

Parametrised successor to the 8x8 serial Game of Life top level. Holds a GRID_WIDTH x GRID_HEIGHT board in a single shift-capable register, loads and unloads it serially, and steps it through the shared `cell_grid` combinational core. Adds bounded multi-generation runs with a start/busy/done handshake, a generation counter, early termination on still-life or extinction, and an output-valid qualifier for the serial unload.

## Interface
- GRID_WIDTH, 8, board columns (>=3)
- GRID_HEIGHT, 8, board rows (>=3)
- GEN_WIDTH, 16, width of generation request and counter
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- mode  input  2  00 load, 01 run, 10 output, 11 hold
- data_in  input  1  serial board bit, used in load mode
- start  input  1  single-cycle run request, honoured in run mode when idle
- gen_req  input  GEN_WIDTH  generations to run; 0 = run until stable or extinct
- data_out  output  1  serial board bit, valid when out_valid
- out_valid  output  1  data_out carries a board bit
- load_full  output  1  DATA_SIZE bits shifted in since entering load mode
- busy  output  1  run in progress
- done  output  1  one-cycle pulse at run completion
- stable  output  1  last completed generation equalled its predecessor
- extinct  output  1  board is all zeros
- generation  output  GEN_WIDTH  generations completed in current run
- din_led, clk_led, dout_led  output  1  mirror data_in, clk, data_out
- mode_leds  output  2  mirror mode

## Operation
- DATA_SIZE = GRID_WIDTH*GRID_HEIGHT; board bit index = row*GRID_WIDTH + col.
- Load (00): each cycle board <= {board[DATA_SIZE-2:0], data_in}; first bit shifted ends at MSB after DATA_SIZE cycles. Load counter increments, saturates at DATA_SIZE; load_full high when saturated. Counter clears on any cycle mode != 00; further shifting after full keeps shifting.
- Run (01), FSM RUN_IDLE/RUN_ACTIVE:
  - RUN_IDLE, start=1: latch gen_req, clear generation and stable, go RUN_ACTIVE. start ignored while busy or outside run mode.
  - RUN_ACTIVE: each cycle board <= next_state, generation += 1.
  - Terminate (return RUN_IDLE, pulse done) when generation+1 == latched request (request != 0), or next_state == board (set stable), or next_state == 0.
  - Simultaneous terminate conditions: single done pulse; stable set if still-life.
  - generation saturates at all-ones; free-run (request 0) continues past saturation.
- Output (10): on entry, output counter clears; board shifts left one bit per cycle, data_out = board MSB, out_valid high for exactly DATA_SIZE cycles, then data_out = 0, out_valid = 0. Shift-out is destructive.
- Hold (11): board, counters, flags frozen; outputs low except status flags.
- Mode change out of run while busy aborts: FSM to RUN_IDLE, busy low next cycle, no done pulse, board keeps last generation.
- extinct is combinational on current board.

## Timing
- Reset (low): board 0, all counters 0, FSM RUN_IDLE; data_out 0, out_valid 0, load_full 0, busy 0, done 0, stable 0, generation 0; extinct 1.
- start sampled at edge N: busy high after edge N; first generation stored at edge N+1.
- Request of K generations: done high in cycle after edge N+K, busy low same cycle; generation = K.
- data_out/out_valid registered: first valid bit one cycle after entering output mode.
- Reset assertion mid-run or mid-shift takes effect immediately; no done pulse.

## Structure
- Package `conway_pkg`: mode enum (MODE_LOAD, MODE_RUN, MODE_OUTPUT, MODE_HOLD), run FSM state enum, DATA_SIZE helper function.
- Reuse existing `cell_grid` for next-state.
- One new sub-module `conway_run_ctrl`: run FSM, generation counter, termination detection, start/busy/done handshake. Top holds board register, load/output counters, LED routing.

## Test plan
- Reset then load 64 bits of a horizontal blinker (row 3, cols 2-4) -> load_full high on cycle 64; output mode returns identical 64-bit stream with out_valid high 64 cycles.
- Blinker, gen_req=3 -> done after 3 generations, generation=3, board vertical blinker, stable=0.
- 2x2 block, gen_req=10 -> done after 1 generation, stable=1, generation=1.
- Single live cell, gen_req=0 -> done after 1 generation, extinct=1, board 0.
- Glider, gen_req=100, mode forced to 11 at generation 5 -> busy low next cycle, no done, generation=5 frozen.
- 5x4 parameterisation (GRID_WIDTH=5, GRID_HEIGHT=4) -> load_full after 20 bits, 20-cycle out_valid window, blinker oscillates correctly.
